// File: rtl/alu_exec_stage_pkg.sv
// Shared op codes, branch selects and FSM encoding for the ALU execute stage.
package alu_exec_stage_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Compare ops leave their outcome in result[0], so blt/bge read the LSB.
    function automatic logic branch_decide(input logic       is_branch,
                                           input logic [2:0] funct3,
                                           input logic       res_zero,
                                           input logic       res_lsb);
        logic taken;
        taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                BEQ:        taken = res_zero;
                BNE:        taken = !res_zero;
                BLT, BLTU:  taken = res_lsb;
                BGE, BGEU:  taken = !res_lsb;
                default:    taken = 1'b0;
            endcase
        end
        return taken;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operation-in / result-out bundle of the ALU execute stage.
interface alu_exec_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            branch_taken;
    logic            busy;

    modport slave (
        input  in_valid, alu_control, operand_a, operand_b, funct3, is_branch,
               flush, out_ready,
        output in_ready, out_valid, result, zero, branch_taken, busy
    );

    modport master (
        output in_valid, alu_control, operand_a, operand_b, funct3, is_branch,
               flush, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken, busy
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter; done is high during the last step and shifted holds the final value.
module alu_serial_shifter
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               kill,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    shifted,
    output logic               done
);

    logic [XLEN-1:0]    work_q;
    logic [SHAMT_W-1:0] count_q;
    logic [3:0]         op_q;
    logic               running_q;

    always_comb begin
        shifted = work_q;
        case (op_q)
            ALU_SLL: shifted = {work_q[XLEN-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, work_q[XLEN-1:1]};
            ALU_SRA: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: shifted = work_q;
        endcase
    end

    assign done = running_q && (count_q == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            count_q   <= '0;
            op_q      <= ALU_ADD;
            running_q <= 1'b0;
        end else if (kill) begin
            running_q <= 1'b0;
        end else if (start) begin
            work_q    <= operand;
            count_q   <= shamt;
            op_q      <= op;
            running_q <= 1'b1;
        end else if (running_q) begin
            work_q  <= shifted;
            count_q <= count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes result and branch decision into an EX/MEM register with valid/ready.
//   state | meaning
//   IDLE  | may accept; out_valid reflects a held single-cycle result
//   SHIFT | serial shifter iterating, busy high
//   DONE  | shift result presented, waiting for out_ready
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_stage_if.slave bus
);

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    result_q, res_d, alu_res, shift_res;
    logic               zero_q, zero_d, taken_q, taken_d;
    logic               br_q, br_d;
    logic [2:0]         f3_q, f3_d;
    logic               load, accept, use_serial, shift_start, shift_done;
    logic [SHAMT_W-1:0] shamt;

    assign shamt        = bus.operand_b[SHAMT_W-1:0];
    assign bus.in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign use_serial   = (SERIAL_SHIFT != 0) && is_shift_op(bus.alu_control) && (shamt != '0);

    always_comb begin
        alu_res = '0;
        case (bus.alu_control)
            ALU_ADD:  alu_res = bus.operand_a + bus.operand_b;
            ALU_SUB:  alu_res = bus.operand_a - bus.operand_b;
            ALU_XOR:  alu_res = bus.operand_a ^ bus.operand_b;
            ALU_OR:   alu_res = bus.operand_a | bus.operand_b;
            ALU_AND:  alu_res = bus.operand_a & bus.operand_b;
            ALU_SLL:  alu_res = bus.operand_a << shamt;
            ALU_SRL:  alu_res = bus.operand_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(bus.operand_a) >>> shamt);
            ALU_SLT:  alu_res[0] = $signed(bus.operand_a) < $signed(bus.operand_b);
            ALU_SLTU: alu_res[0] = bus.operand_a < bus.operand_b;
            default:  alu_res = '0;
        endcase
    end

    generate
        if (SERIAL_SHIFT != 0) begin : g_serial
            alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (shift_start),
                .kill    (bus.flush),
                .op      (bus.alu_control),
                .operand (bus.operand_a),
                .shamt   (shamt),
                .shifted (shift_res),
                .done    (shift_done)
            );
        end else begin : g_comb
            assign shift_res  = '0;
            assign shift_done = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        shift_start = 1'b0;
        res_d       = alu_res;
        br_d        = bus.is_branch;
        f3_d        = bus.funct3;
        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
                    if (accept) begin
                        if (use_serial) begin
                            shift_start = 1'b1;
                            state_d     = SHIFT;
                        end else begin
                            load        = 1'b1;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        load        = 1'b1;
                        res_d       = shift_res;
                        br_d        = br_q;
                        f3_d        = f3_q;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
        zero_d  = (res_d == '0);
        taken_d = branch_decide(br_d, f3_d, zero_d, res_d[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            taken_q     <= 1'b0;
            br_q        <= 1'b0;
            f3_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                result_q <= res_d;
                zero_q   <= zero_d;
                taken_q  <= taken_d;
            end
            if (shift_start) begin
                br_q <= bus.is_branch;
                f3_q <= bus.funct3;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.branch_taken = taken_q;
    assign bus.busy         = (state_q == SHIFT);

endmodule
